// File: rtl/apb_completer_regs_pkg.sv
// rtl/apb_completer_regs_pkg.sv - shared types, constants and byte-merge helper for the APB completer
package apb_completer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP_SEEN,
    ACCESS
  } apb_state_e;

  localparam int WORD_BYTES = 4;
  localparam int ADDR_LSB   = 2;

  function automatic logic [31:0] strb_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  strb);
    logic [31:0] merged;
    merged = old_word;
    for (int k = 0; k < WORD_BYTES; k++) begin
      if (strb[k]) merged[8*k +: 8] = new_word[8*k +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/apb_completer_regs_if.sv
// rtl/apb_completer_regs_if.sv - APB4 bus signal bundle with requester/completer views
interface apb_completer_regs_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    PSEL;
  logic                    PENABLE;
  logic                    PWRITE;
  logic [ADDR_WIDTH-1:0]   PADDR;
  logic [DATA_WIDTH-1:0]   PWDATA;
  logic [DATA_WIDTH/8-1:0] PSTRB;
  logic [2:0]              PPROT;
  logic [DATA_WIDTH-1:0]   PRDATA;
  logic                    PREADY;
  logic                    PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_completer_regs_regfile.sv
// rtl/apb_completer_regs_regfile.sv - register storage with byte-strobe write port and combinational read
module apb_completer_regfile
  import apb_completer_pkg::*;
#(
  parameter int          NUM_REGS   = 8,
  parameter int          DATA_WIDTH = 32,
  parameter int          IDX_W      = 3,
  parameter logic [31:0] RESET_VAL  = 32'h0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic [IDX_W-1:0]        addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  output logic [DATA_WIDTH-1:0]   rdata
);
  logic [DATA_WIDTH-1:0] mem [NUM_REGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= RESET_VAL;
    end else if (we) begin
      mem[addr] <= strb_merge(mem[addr], wdata, wstrb);
    end
  end

  assign rdata = mem[addr];
endmodule

// File: rtl/apb_completer_regs.sv
// rtl/apb_completer_regs.sv - APB4 completer: FSM, wait-state counter, decode, register bank
// Optional: APB_COMPLETER_PROT_CHECK_EN makes unprivileged (PPROT[0]=0) transfers error out.
module apb_completer_regs
  import apb_completer_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 32,
  parameter int          DATA_WIDTH  = 32,
  parameter int          NUM_REGS    = 8,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] RESET_VAL   = 32'h0
) (
  input  logic                PCLK,
  input  logic                PRESET,
  apb_completer_regs_if.slave apb
);
  localparam int IDX_W = $clog2(NUM_REGS);
  localparam int CNT_W = 4;

  apb_state_e                      state;
  logic [CNT_W-1:0]                wait_cnt;
  logic                            err_q;
  logic                            pready_q;
  logic                            pslverr_q;
  logic [DATA_WIDTH-1:0]           prdata_q;
  logic [ADDR_WIDTH-ADDR_LSB-1:0]  word_idx;
  logic                            decode_err;
  logic [DATA_WIDTH-1:0]           rd_data;
  logic                            commit;

  assign word_idx = apb.PADDR[ADDR_WIDTH-1:ADDR_LSB];

  always_comb begin
    decode_err = (apb.PADDR[ADDR_LSB-1:0] != '0) ||
                 (word_idx >= (ADDR_WIDTH-ADDR_LSB)'(NUM_REGS));
`ifdef APB_COMPLETER_PROT_CHECK_EN
    decode_err = decode_err || !apb.PPROT[0];
`endif
  end

`ifndef APB_COMPLETER_PROT_CHECK_EN
  logic unused_prot;
  assign unused_prot = ^apb.PPROT;
`endif

  // Completion edge: PREADY already registered high and the requester still in access phase.
  assign commit = (state != IDLE) && pready_q && apb.PSEL && apb.PENABLE &&
                  apb.PWRITE && !err_q;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      err_q     <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          pready_q  <= 1'b0;
          pslverr_q <= 1'b0;
          prdata_q  <= '0;
          if (apb.PSEL && !apb.PENABLE) begin
            state    <= SETUP_SEEN;
            wait_cnt <= CNT_W'(WAIT_STATES);
            err_q    <= decode_err;
            if (WAIT_STATES == 0) begin
              pready_q  <= 1'b1;
              pslverr_q <= decode_err;
              prdata_q  <= (!apb.PWRITE && !decode_err) ? rd_data : '0;
            end
          end
        end
        SETUP_SEEN, ACCESS: begin
          if (!apb.PSEL || pready_q) begin
            state     <= IDLE;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
          end else begin
            // The first access cycle already counts down, so PREADY lands in access cycle WAIT_STATES+1.
            state <= ACCESS;
            if (wait_cnt != '0) begin
              wait_cnt <= wait_cnt - 1'b1;
              if (wait_cnt == CNT_W'(1)) begin
                pready_q  <= 1'b1;
                pslverr_q <= err_q;
                prdata_q  <= (!apb.PWRITE && !err_q) ? rd_data : '0;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign apb.PREADY  = pready_q;
  assign apb.PSLVERR = pslverr_q;
  assign apb.PRDATA  = prdata_q;

  apb_completer_regfile #(
    .NUM_REGS   (NUM_REGS),
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_W      (IDX_W),
    .RESET_VAL  (RESET_VAL)
  ) u_regfile (
    .clk   (PCLK),
    .rst   (PRESET),
    .we    (commit),
    .addr  (word_idx[IDX_W-1:0]),
    .wdata (apb.PWDATA),
    .wstrb (apb.PSTRB),
    .rdata (rd_data)
  );
endmodule
